// File: rtl/entrada_time_pkg.sv
// Shared types and default sizing for the team-entry controller.
// The optional timeout (macro ENTRY_TIMEOUT_EN) uses DEF_TIMEOUT/DEF_TIMER_W.
package entrada_time_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OPEN   = 2'b01,
        CLOSED = 2'b10
    } state_t;

    localparam int DEF_MAX_TEAMS = 8;
    localparam int DEF_MIN_TEAMS = 2;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_TIMEOUT   = 16;
    localparam int DEF_TIMER_W   = 5;
endpackage

// File: rtl/team_entry_ctrl_if.sv
// Front-panel controls into the entry controller and its status outputs.
interface team_entry_ctrl_if #(parameter int CNT_W = 4);
    logic             start;
    logic             entrada;
    logic             close;
    logic             cancel;
    logic [CNT_W-1:0] teams;
    logic             busy;
    logic             full;
    logic             done;

    modport master (output start, entrada, close, cancel,
                    input  teams, busy, full, done);
    modport slave  (input  start, entrada, close, cancel,
                    output teams, busy, full, done);
endinterface

// File: rtl/counter_sync_en.sv
// Synchronous up-counter: clear (reset) and clr (load zero) beat en.
module counter_sync_en #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clock) begin
        if (clear || clr) q <= '0;
        else if (en)      q <= q + 1'b1;
    end
endmodule

// File: rtl/team_entry_ctrl.sv
// Entry-window sequencer: counts team registrations, closes on max/close/timeout.
// Inactivity timeout is built only when ENTRY_TIMEOUT_EN is defined.
//   state  | meaning
//   IDLE   | no window, waiting for start
//   OPEN   | window open, counting entries
//   CLOSED | window ended, count held for the next stage
module team_entry_ctrl
    import entrada_time_pkg::*;
#(
    parameter int MAX_TEAMS = DEF_MAX_TEAMS,
    parameter int MIN_TEAMS = DEF_MIN_TEAMS,
    parameter int CNT_W     = DEF_CNT_W
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TIMER_W   = DEF_TIMER_W
`endif
) (
    input  logic           clock,
    input  logic           clear,
    team_entry_ctrl_if.slave bus
);
    localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_TEAMS);
    localparam logic [CNT_W:0] MIN_C = (CNT_W+1)'(MIN_TEAMS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] teams;
    logic [CNT_W:0]   cnt_inc;
    logic             inc, teams_clr, teams_en;
    logic             done_q, done_nxt, full_q, full_nxt;

    counter_sync_en #(.CNT_W(CNT_W)) u_teams (
        .clock (clock), .clear (clear), .clr (teams_clr), .en (teams_en), .q (teams)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT - 1);
    logic [TIMER_W-1:0] timer;
    logic               timer_clr, timer_en, timeout_hit;

    counter_sync_en #(.CNT_W(TIMER_W)) u_timer (
        .clock (clock), .clear (clear), .clr (timer_clr), .en (timer_en), .q (timer)
    );
    assign timeout_hit = (timer == TO_LAST);
`endif

    // Count can never exceed MAX_TEAMS, so the incremented value is the close test input.
    assign inc     = bus.entrada && ({1'b0, teams} < MAX_C);
    assign cnt_inc = {1'b0, teams} + {{CNT_W{1'b0}}, inc};

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            done_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            full_q <= full_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        teams_clr = 1'b0;
        teams_en  = 1'b0;
        done_nxt  = 1'b0;
        full_nxt  = full_q;
`ifdef ENTRY_TIMEOUT_EN
        timer_clr = 1'b0;
        timer_en  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = OPEN;
                    teams_clr = 1'b1;
                    full_nxt  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                    timer_clr = 1'b1;
`endif
                end
            end
            OPEN: begin
                if (bus.cancel) begin
                    state_nxt = IDLE;
                    teams_clr = 1'b1;
                    full_nxt  = 1'b0;
                end else begin
                    teams_en = inc;
                    if (inc && (cnt_inc == MAX_C)) begin
                        state_nxt = CLOSED;
                        done_nxt  = 1'b1;
                        full_nxt  = 1'b1;
                    end else if (bus.close && (cnt_inc >= MIN_C)) begin
                        state_nxt = CLOSED;
                        done_nxt  = 1'b1;
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (!bus.entrada && timeout_hit && ({1'b0, teams} >= MIN_C)) begin
                        state_nxt = CLOSED;
                        done_nxt  = 1'b1;
                    end
                    // Too few teams at timeout: restart the inactivity window.
                    timer_clr = bus.entrada || timeout_hit;
                    timer_en  = !bus.entrada && !timeout_hit;
`endif
                end
            end
            CLOSED: begin
                if (bus.start) begin
                    state_nxt = OPEN;
                    teams_clr = 1'b1;
                    full_nxt  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                    timer_clr = 1'b1;
`endif
                end else if (bus.cancel) begin
                    state_nxt = IDLE;
                    teams_clr = 1'b1;
                    full_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.teams = teams;
    assign bus.busy  = (state == OPEN);
    assign bus.full  = full_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_team_entry_ctrl.sv
// Directed scoreboard bench for team_entry_ctrl (MAX_TEAMS=8, MIN_TEAMS=2).
module tb_team_entry_ctrl;
    typedef struct {
        string      tag;
        logic [3:0] teams;
        logic       busy;
        logic       full;
        logic       done;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    team_entry_ctrl_if #(.CNT_W(4)) bus ();

    team_entry_ctrl #(.MAX_TEAMS(8), .MIN_TEAMS(2), .CNT_W(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_one(input string tag, input string field,
                             input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, got, want);
        end
    endtask

    task automatic step(input string tag, input logic clr, input logic s, input logic e,
                        input logic c, input logic x, input int et,
                        input logic eb, input logic ef, input logic ed);
        exp_t r;
        clear       = clr;
        bus.start   = s;
        bus.entrada = e;
        bus.close   = c;
        bus.cancel  = x;
        exp_q.push_back('{tag, 4'(et), eb, ef, ed});
        @(posedge clock);
        #1;
        r = exp_q.pop_front();
        check_one(r.tag, "teams", bus.teams, r.teams);
        check_one(r.tag, "busy",  {3'b0, bus.busy}, {3'b0, r.busy});
        check_one(r.tag, "full",  {3'b0, bus.full}, {3'b0, r.full});
        check_one(r.tag, "done",  {3'b0, bus.done}, {3'b0, r.done});
    endtask

    initial begin
        bus.start = 1'b0; bus.entrada = 1'b0; bus.close = 1'b0; bus.cancel = 1'b0;
        @(posedge clock); #1;

        // reset dominates start/entrada
        step("rst0", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("open", 0, 1, 0, 0, 0, 0, 1, 0, 0);

        // fill to MAX: auto-close on the 8th entry
        for (int k = 1; k <= 7; k++) step("fill", 0, 0, 1, 0, 0, k, 1, 0, 0);
        step("fill8", 0, 0, 1, 0, 0, 8, 0, 1, 1);
        step("post8", 0, 0, 0, 0, 0, 8, 0, 1, 0);
        step("ent9",  0, 0, 1, 0, 0, 8, 0, 1, 0);

        // reopen from CLOSED
        step("reopen", 0, 1, 0, 0, 0, 0, 1, 0, 0);

        // close below MIN ignored, entry+close together closes at 2
        step("e1",    0, 0, 1, 0, 0, 1, 1, 0, 0);
        step("cl_lo", 0, 0, 0, 1, 0, 1, 1, 0, 0);
        step("e_cl",  0, 0, 1, 1, 0, 2, 0, 0, 1);
        step("held",  0, 0, 0, 0, 0, 2, 0, 0, 0);
        step("ign_cl",0, 0, 1, 1, 0, 2, 0, 0, 0);

        // cancel beats entrada
        step("open2", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) step("e3", 0, 0, 1, 0, 0, k, 1, 0, 0);
        step("cancel", 0, 0, 1, 0, 1, 0, 0, 0, 0);
        step("idle_e", 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // clear mid-window
        step("open3", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) step("e5", 0, 0, 1, 0, 0, k, 1, 0, 0);
        step("clr_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after",   0, 0, 0, 0, 0, 0, 0, 0, 0);

        // one entry then long idle: never closes (below MIN)
        step("open4", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        step("e1b",   0, 0, 1, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 48; k++) step("idle1", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("cancel2", 0, 0, 0, 0, 1, 0, 0, 0, 0);

`ifdef ENTRY_TIMEOUT_EN
        // two entries then idle: done 16 edges after the last entry
        step("open5", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        step("t_e1",  0, 0, 1, 0, 0, 1, 1, 0, 0);
        step("t_e2",  0, 0, 1, 0, 0, 2, 1, 0, 0);
        for (int k = 1; k <= 15; k++) step("t_wait", 0, 0, 0, 0, 0, 2, 1, 0, 0);
        step("t_done", 0, 0, 0, 0, 0, 2, 0, 0, 1);
        step("t_held", 0, 0, 0, 0, 0, 2, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/team_entry_ctrl.md
Name: team_entry_ctrl

Overview:
- Controller that sequences the team-entry counter for the final-project game: opens an entry window, counts registered teams, then closes the window.
- Each entry pulse increments the team count.
- The window closes on MAX_TEAMS entries, on an explicit close request, or (optionally) on inactivity timeout.
- Sits between the debounced front-panel inputs and the game-start logic; `teams`/`done` feed the next stage.

Parameters:
- MAX_TEAMS, 8, maximum number of teams accepted per window (≥1).
- MIN_TEAMS, 2, minimum count required before close/timeout may end the window (1..MAX_TEAMS).
- CNT_W, 4, width of `teams`; must hold MAX_TEAMS.
- TIMEOUT, 16, inactivity window in clock cycles (used only with ENTRY_TIMEOUT_EN).
- TIMER_W, 5, width of the inactivity timer; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  open a new entry window (level sampled each edge).
- entrada  in  1  one team registration, single-cycle pulse.
- close  in  1  request end of window.
- cancel  in  1  abort window, discard count.
- teams  out  CNT_W  registered team count.
- busy  out  1  high while window is open.
- full  out  1  high when teams == MAX_TEAMS.
- done  out  1  one-cycle pulse on window close.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: clear=1 at a rising edge puts state=IDLE, teams=0, busy=0, full=0, done=0, timer=0. Takes effect mid-window with no done pulse. Highest priority.
- States: IDLE, OPEN, CLOSED (2-bit encoding). All outputs are registered; busy=1 exactly in OPEN.
- IDLE:
  - start=1 -> OPEN on that edge; teams=0, timer=0.
  - entrada, close and cancel are ignored.
- OPEN, priority order cancel > close/entrada > timeout:
  - cancel=1 -> IDLE; teams=0; no done.
  - entrada=1 with teams<MAX_TEAMS -> teams+1; timer=0.
  - entrada=1 with teams==MAX_TEAMS cannot occur in OPEN, because the window auto-closes on the increment that reaches MAX_TEAMS.
  - Auto-close: when teams+1 == MAX_TEAMS, go to CLOSED on the same edge; done=1 and full=1 on that edge.
  - close=1 with the post-edge count ≥ MIN_TEAMS -> CLOSED; done=1. Otherwise close is ignored and stays OPEN.
  - Simultaneous entrada and close: the entry is counted first, and the close test uses the incremented count.
  - start is ignored in OPEN.
- CLOSED:
  - teams is held; done is low after its single pulse.
  - start=1 -> OPEN; teams=0; full=0.
  - cancel=1 -> IDLE; teams=0.
  - All other inputs are ignored.
- done is high for exactly one cycle per close, never on cancel or clear.
- teams never wraps: it saturates by construction at MAX_TEAMS.
- Latency: every input takes effect on the next rising edge (1 cycle).

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- With the macro defined:
  - In OPEN, the timer increments each cycle without entrada and resets to 0 on entrada.
  - When timer == TIMEOUT-1, no entrada and no cancel this cycle, and teams ≥ MIN_TEAMS: go to CLOSED with done=1.
  - If teams < MIN_TEAMS at that point, the timer resets to 0 and the window stays OPEN.
  - close, entrada and cancel take precedence over timeout.
- Without the macro:
  - The timer and TIMEOUT/TIMER_W logic are absent.
  - The window ends only on MAX_TEAMS, close or cancel.

Decomposition:
- Shared package `entrada_time_pkg`:
  - state typedef (IDLE/OPEN/CLOSED) and encoding constants.
  - default MAX_TEAMS/MIN_TEAMS/TIMEOUT values.
- One natural sub-module: `counter_sync_en`.
  - Synchronous up-counter with clock, clear, clr (sync load-zero), en, Q[CNT_W].
  - Used for teams; a second instance is used for the timer when ENTRY_TIMEOUT_EN is defined.
- The FSM stays in team_entry_ctrl.

Test Plan:
- clear=1 for 2 cycles with start=1 and entrada=1 -> state IDLE, teams=0, busy=0, done never high; release clear, start=1 for 1 cycle -> busy=1 next edge, teams=0.
- OPEN, 8 entrada pulses (MAX_TEAMS=8) -> teams steps 1..8; on the 8th edge busy=0, full=1, done=1 for exactly 1 cycle; a 9th entrada -> teams stays 8.
- OPEN, 1 entrada then close -> close ignored, busy=1, teams=1; entrada and close in the same cycle -> teams=2, CLOSED, done pulse.
- OPEN with teams=3, cancel and entrada together -> IDLE, teams=0, no done; clear asserted mid-window at teams=5 -> teams=0, IDLE, no done.
- ENTRY_TIMEOUT_EN, TIMEOUT=16:
  - 2 entries then idle -> done exactly 16 cycles after the last entrada edge, teams=2.
  - 1 entry then idle -> no close after 16, 32 or 48 cycles.
- From CLOSED with teams=8, start=1 -> OPEN, teams=0, full=0, busy=1 on the next edge.
